// File: rtl/arp_rx_parser.sv
// ARP payload parser: validates the 28-byte ARP header on a DATA_W beat stream and
// presents one result per good frame. Define ARP_RX_STATS_EN to add stat_ok/stat_err counters.
module arp_rx_parser #(
    parameter int          DATA_W       = 8,
    parameter logic [31:0] LOCAL_IP     = 32'hC0A80164,
    parameter int          ACCEPT_REPLY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       m_op,
    output logic [47:0]       m_sha,
    output logic [31:0]       m_spa,
    output logic [47:0]       m_tha,
    output logic [31:0]       m_tpa,
    output logic              m_for_us,
    output logic              err,
    output logic [2:0]        err_code
`ifdef ARP_RX_STATS_EN
    ,
    output logic [15:0]       stat_ok,
    output logic [15:0]       stat_err
`endif
);

    localparam int BPB       = DATA_W / 8;
    localparam int HDR_BYTES = 28;

    typedef enum logic [2:0] {IDLE, HDR, ADDR, TAIL, DROP} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [5:0]  cnt_sum;
    logic        beat_active;
    logic        complete;
    logic        load;
    logic        ovf;
    logic        err_next;
    logic [2:0]  code_next;
    logic        fail;
    logic [2:0]  fail_code;

    logic [7:0]  lane [BPB];
    logic [8*HDR_BYTES-1:0] cur_bytes;

    logic [15:0] htype, ptype, oper;
    logic [7:0]  hlen, plen;
    logic [47:0] sha, tha;
    logic [31:0] spa, tpa;
    logic        oper_ok;

    genvar gi;

    // Lane 0 carries the earliest byte of the beat.
    generate
        for (gi = 0; gi < BPB; gi++) begin : g_lane
            assign lane[gi] = s_data[DATA_W-1-8*gi -: 8];
        end
    endgenerate

    assign beat_active = s_valid && (state_reg == IDLE || state_reg == HDR || state_reg == ADDR);

    // Per header byte: the stored value, overridden by the lane landing on it this beat,
    // so a field can be checked on the same beat that completes it.
    generate
        for (gi = 0; gi < HDR_BYTES; gi++) begin : g_byte
            logic [7:0] byte_reg;
            logic [7:0] byte_cur;

            always_comb begin
                byte_cur = byte_reg;
                for (int l = 0; l < BPB; l++) begin
                    if (beat_active && (int'(cnt_reg) + l == gi)) begin
                        byte_cur = lane[l];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    byte_reg <= '0;
                end else if (beat_active) begin
                    byte_reg <= byte_cur;
                end
            end

            assign cur_bytes[8*(HDR_BYTES-1-gi) +: 8] = byte_cur;
        end
    endgenerate

    assign htype = cur_bytes[223:208];
    assign ptype = cur_bytes[207:192];
    assign hlen  = cur_bytes[191:184];
    assign plen  = cur_bytes[183:176];
    assign oper  = cur_bytes[175:160];
    assign sha   = cur_bytes[159:112];
    assign spa   = cur_bytes[111:80];
    assign tha   = cur_bytes[79:32];
    assign tpa   = cur_bytes[31:0];

    assign oper_ok = (oper == 16'd1) || ((ACCEPT_REPLY != 0) && (oper == 16'd2));
    assign cnt_sum = cnt_reg + 6'(BPB);

    function automatic logic covers(input logic [5:0] c, input int pos);
        return (int'(c) <= pos) && (pos < int'(c) + BPB);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        code_next  = 3'd0;
        complete   = 1'b0;
        fail       = 1'b1;
        fail_code  = 3'd0;
        case (state_reg)
            IDLE, HDR, ADDR: begin
                if (s_valid) begin
                    // Fields complete in byte order, so the earliest failing check wins.
                    if (covers(cnt_reg, 1) && htype != 16'h0001) begin
                        fail_code = 3'd1;
                    end else if (covers(cnt_reg, 3) && ptype != 16'h0800) begin
                        fail_code = 3'd2;
                    end else if (covers(cnt_reg, 5) && (hlen != 8'd6 || plen != 8'd4)) begin
                        fail_code = 3'd3;
                    end else if (covers(cnt_reg, 7) && !oper_ok) begin
                        fail_code = 3'd4;
                    end else begin
                        fail = 1'b0;
                    end

                    if (fail) begin
                        err_next   = 1'b1;
                        code_next  = fail_code;
                        cnt_next   = '0;
                        state_next = s_last ? IDLE : DROP;
                    end else if (covers(cnt_reg, 27)) begin
                        complete   = 1'b1;
                        cnt_next   = '0;
                        state_next = s_last ? IDLE : TAIL;
                    end else if (s_last) begin
                        err_next   = 1'b1;
                        code_next  = 3'd5;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next   = cnt_sum;
                        state_next = (cnt_sum < 6'd8) ? HDR : ADDR;
                    end
                end
            end
            TAIL, DROP: begin
                if (s_valid && s_last) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A result completing during a handshake may take the slot being freed.
    assign load = complete && (!m_valid || m_ready);
    assign ovf  = complete && m_valid && !m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_op     <= '0;
            m_sha    <= '0;
            m_spa    <= '0;
            m_tha    <= '0;
            m_tpa    <= '0;
            m_for_us <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            err      <= err_next || ovf;
            err_code <= ovf ? 3'd6 : code_next;
            if (load) begin
                m_valid  <= 1'b1;
                m_op     <= oper;
                m_sha    <= sha;
                m_spa    <= spa;
                m_tha    <= tha;
                m_tpa    <= tpa;
                m_for_us <= (tpa == LOCAL_IP);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef ARP_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ok  <= '0;
            stat_err <= '0;
        end else begin
            if (load && stat_ok != 16'hFFFF) begin
                stat_ok <= stat_ok + 16'd1;
            end
            if ((err_next || ovf) && stat_err != 16'hFFFF) begin
                stat_err <= stat_err + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arp_rx_parser.sv
// Randomized bench for arp_rx_parser: a byte-level rule model predicts the outcome and
// timing of every frame on an 8-bit (replies accepted) and a 32-bit (replies rejected) instance.
module tb_arp_rx_parser;

    localparam logic [31:0] LIP = 32'hC0A80164;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        int          cyc;
        bit          is_err;
        logic [2:0]  code;
        logic [176:0] fields;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data_a;
    logic [31:0] s_data_b;
    logic [1:0]  s_valid, s_last, m_ready;

    logic        m_valid_a, m_for_us_a, err_a;
    logic [15:0] m_op_a;
    logic [47:0] m_sha_a, m_tha_a;
    logic [31:0] m_spa_a, m_tpa_a;
    logic [2:0]  err_code_a;
    logic        m_valid_b, m_for_us_b, err_b;
    logic [15:0] m_op_b;
    logic [47:0] m_sha_b, m_tha_b;
    logic [31:0] m_spa_b, m_tpa_b;
    logic [2:0]  err_code_b;
`ifdef ARP_RX_STATS_EN
    logic [15:0] stat_ok_a, stat_err_a, stat_ok_b, stat_err_b;
`endif

    ev_t evq0[$];
    ev_t evq1[$];
    int  beat_cyc[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  exp_ok[2];
    int  exp_err[2];

    arp_rx_parser #(.DATA_W(8), .LOCAL_IP(LIP), .ACCEPT_REPLY(1)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data_a), .s_valid(s_valid[0]), .s_last(s_last[0]),
        .m_valid(m_valid_a), .m_ready(m_ready[0]), .m_op(m_op_a), .m_sha(m_sha_a),
        .m_spa(m_spa_a), .m_tha(m_tha_a), .m_tpa(m_tpa_a), .m_for_us(m_for_us_a),
        .err(err_a), .err_code(err_code_a)
`ifdef ARP_RX_STATS_EN
        , .stat_ok(stat_ok_a), .stat_err(stat_err_a)
`endif
    );

    arp_rx_parser #(.DATA_W(32), .LOCAL_IP(LIP), .ACCEPT_REPLY(0)) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data_b), .s_valid(s_valid[1]), .s_last(s_last[1]),
        .m_valid(m_valid_b), .m_ready(m_ready[1]), .m_op(m_op_b), .m_sha(m_sha_b),
        .m_spa(m_spa_b), .m_tha(m_tha_b), .m_tpa(m_tpa_b), .m_for_us(m_for_us_b),
        .err(err_b), .err_code(err_code_b)
`ifdef ARP_RX_STATS_EN
        , .stat_ok(stat_ok_b), .stat_err(stat_err_b)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every consumed result and every error pulse with its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid_a && m_ready[0])
                evq0.push_back('{cyc, 1'b0, 3'd0, {m_op_a, m_sha_a, m_spa_a, m_tha_a, m_tpa_a, m_for_us_a}});
            if (err_a)
                evq0.push_back('{cyc, 1'b1, err_code_a, 177'd0});
            if (m_valid_b && m_ready[1])
                evq1.push_back('{cyc, 1'b0, 3'd0, {m_op_b, m_sha_b, m_spa_b, m_tha_b, m_tpa_b, m_for_us_b}});
            if (err_b)
                evq1.push_back('{cyc, 1'b1, err_code_b, 177'd0});
        end
    end

    function automatic bq_t make_frame(input logic [15:0] ht, input logic [15:0] pt,
                                       input logic [7:0] hl, input logic [7:0] pl,
                                       input logic [15:0] op, input logic [47:0] sha,
                                       input logic [31:0] spa, input logic [47:0] tha,
                                       input logic [31:0] tpa, input int pad);
        logic [223:0] h;
        bq_t q;
        h = {ht, pt, hl, pl, op, sha, spa, tha, tpa};
        for (int i = 0; i < 28; i++) q.push_back(h[223-8*i -: 8]);
        for (int i = 0; i < pad; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic bq_t good_frame(input logic [47:0] sha, input logic [31:0] tpa,
                                       input logic [15:0] op, input int pad);
        return make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, op, sha, 32'hC0A80102, 48'd0, tpa, pad);
    endfunction

    // Outcome of a frame from the ARP rules: which error (if any) and the index of the
    // byte whose beat decides it.
    function automatic void model(input bq_t f, input bit accept, output bit is_err,
                                  output logic [2:0] code, output int det);
        int n;
        n = f.size();
        is_err = 1'b1;
        code = 3'd5;
        det = n - 1;
        if (n < 2) return;
        det = 1;
        if ({f[0], f[1]} != 16'h0001) begin code = 3'd1; return; end
        det = n - 1;
        if (n < 4) return;
        det = 3;
        if ({f[2], f[3]} != 16'h0800) begin code = 3'd2; return; end
        det = n - 1;
        if (n < 6) return;
        det = 5;
        if (f[4] != 8'd6 || f[5] != 8'd4) begin code = 3'd3; return; end
        det = n - 1;
        if (n < 8) return;
        det = 7;
        if (!({f[6], f[7]} == 16'd1 || (accept && {f[6], f[7]} == 16'd2))) begin code = 3'd4; return; end
        det = n - 1;
        if (n < 28) return;
        is_err = 1'b0;
        code = 3'd0;
        det = 27;
    endfunction

    function automatic logic [176:0] exp_fields(input bq_t f);
        logic [223:0] h;
        h = '0;
        for (int i = 0; i < 28 && i < f.size(); i++) h = {h[215:0], f[i]};
        return {h[175:0], h[31:0] == LIP};
    endfunction

    task automatic send(input int d, input bq_t f, input bit gaps);
        int bpb, nb;
        logic [31:0] w;
        bpb = (d == 0) ? 1 : 4;
        nb = f.size() / bpb;
        beat_cyc.delete();
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                @(posedge clk); #1;
                s_valid[d] = 1'b0;
                s_last[d] = 1'($urandom);
                s_data_a = 8'($urandom);
                s_data_b = $urandom;
            end
            @(posedge clk); #1;
            w = '0;
            for (int k = 0; k < bpb; k++) w = {w[23:0], f[b*bpb+k]};
            if (d == 0) s_data_a = w[7:0];
            else        s_data_b = w;
            s_valid[d] = 1'b1;
            s_last[d] = (b == nb - 1);
            beat_cyc.push_back(cyc);
        end
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            s_valid[d] = 1'b0;
            s_last[d] = 1'b0;
        end
    endtask

    task automatic run_frame(input int d, input bq_t f, input bit gaps, input string name);
        bit xe;
        logic [2:0] xc;
        int det, bpb, xcyc, nq;
        ev_t e;
        logic [176:0] xf;
        bpb = (d == 0) ? 1 : 4;
        send(d, f, gaps);
        idle(d, 4);
        model(f, d == 0, xe, xc, det);
        xcyc = beat_cyc[det / bpb] + 1;
        xf = exp_fields(f);
        if (xe) exp_err[d]++; else exp_ok[d]++;
        nq = (d == 0) ? evq0.size() : evq1.size();
        $display("frame %s dut%0d len %0d expect err=%0b code=%0d events=%0d", name, d, f.size(), xe, xc, nq);
        checks++;
        if (nq !== 1) begin
            errors++;
            $display("FAIL %s event_count got %0d want 1", name, nq);
        end
        if (nq > 0) begin
            if (d == 0) e = evq0.pop_front();
            else        e = evq1.pop_front();
            checks++;
            if (e.is_err !== xe) begin
                errors++;
                $display("FAIL %s kind got err=%0b want err=%0b", name, e.is_err, xe);
            end
            checks++;
            if (e.cyc !== xcyc) begin
                errors++;
                $display("FAIL %s timing got cycle %0d want %0d", name, e.cyc, xcyc);
            end
            if (xe && e.is_err) begin
                checks++;
                if (e.code !== xc) begin
                    errors++;
                    $display("FAIL %s err_code got %0d want %0d", name, e.code, xc);
                end
            end else if (!xe && !e.is_err) begin
                checks++;
                if (e.fields !== xf) begin
                    errors++;
                    $display("FAIL %s fields got %h want %h", name, e.fields, xf);
                end
            end
        end
        evq0.delete();
        evq1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 2'b00;
        s_last = 2'b00;
        m_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        evq0.delete();
        evq1.delete();
        exp_ok = '{0, 0};
        exp_err = '{0, 0};
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({m_valid_a, err_a, err_code_a, m_op_a, m_sha_a, m_spa_a, m_tha_a, m_tpa_a, m_for_us_a} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs got %h want 0", {m_valid_a, err_a, err_code_a, m_op_a, m_sha_a, m_spa_a, m_tha_a, m_tpa_a, m_for_us_a});
        end
        checks++;
        if ({m_valid_b, err_b, err_code_b, m_op_b, m_sha_b, m_spa_b, m_tha_b, m_tpa_b, m_for_us_b} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs got %h want 0", {m_valid_b, err_b, err_code_b, m_op_b, m_sha_b, m_spa_b, m_tha_b, m_tpa_b, m_for_us_b});
        end
`ifdef ARP_RX_STATS_EN
        checks++;
        if ({stat_ok_a, stat_err_a, stat_ok_b, stat_err_b} !== 64'd0) begin
            errors++;
            $display("FAIL reset_stats got %h want 0", {stat_ok_a, stat_err_a, stat_ok_b, stat_err_b});
        end
`endif
    endtask

    task automatic test_basic();
        run_frame(0, good_frame(48'h020000000001, LIP, 16'd1, 18), 1'b0, "basic8");
        run_frame(1, good_frame(48'h020000000001, LIP, 16'd1, 20), 1'b1, "basic32_gaps");
        run_frame(1, good_frame(48'h020000000001, 32'hC0A80105, 16'd1, 20), 1'b1, "basic32_not_us");
    endtask

    task automatic test_htype();
        run_frame(0, make_frame(16'h0006, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h020000000001,
                                32'hC0A80102, 48'd0, LIP, 18), 1'b0, "htype_bad");
        run_frame(0, good_frame(48'h0A0B0C0D0E0F, LIP, 16'd1, 4), 1'b0, "after_htype");
    endtask

    task automatic test_oper();
        run_frame(1, good_frame(48'h020000000002, LIP, 16'd2, 4), 1'b0, "reply_rejected");
        run_frame(0, good_frame(48'h020000000002, LIP, 16'd2, 4), 1'b0, "reply_accepted");
    endtask

    task automatic test_trunc();
        bq_t f;
        f = good_frame(48'h020000000003, LIP, 16'd1, 0);
        while (f.size() > 21) void'(f.pop_back());
        run_frame(0, f, 1'b0, "trunc_byte20");
        run_frame(0, good_frame(48'h020000000004, LIP, 16'd1, 3), 1'b0, "after_trunc");
        while (f.size() > 20) void'(f.pop_back());
        run_frame(1, f, 1'b0, "trunc32");
        run_frame(1, good_frame(48'h020000000005, LIP, 16'd1, 0), 1'b0, "after_trunc32");
    endtask

    task automatic test_reset_mid();
        bq_t f;
        f = good_frame(48'h020000000006, LIP, 16'd1, 2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            s_valid[0] = 1'b1;
            s_last[0] = 1'b0;
            s_data_a = f[i];
        end
        @(posedge clk); #1;
        s_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        evq0.delete();
        evq1.delete();
        exp_ok = '{0, 0};
        exp_err = '{0, 0};
        run_frame(0, f, 1'b0, "after_mid_reset");
    endtask

    function automatic bq_t rand_frame(input int bpb);
        int mode, lim;
        logic [15:0] ht, pt, op;
        logic [7:0] hl, pl;
        logic [31:0] tpa;
        bq_t q;
        mode = $urandom_range(0, 6);
        ht = 16'h0001; pt = 16'h0800; hl = 8'd6; pl = 8'd4;
        op = 16'($urandom_range(1, 2));
        if (mode == 1) ht = 16'($urandom_range(2, 65535));
        if (mode == 2) begin
            pt = 16'($urandom);
            if (pt == 16'h0800) pt = 16'h86DD;
        end
        if (mode == 3) begin
            if ($urandom_range(0, 1) == 1) hl = 8'($urandom_range(0, 5));
            else                           pl = 8'($urandom_range(5, 16));
        end
        if (mode == 4) op = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(3, 9));
        tpa = ($urandom_range(0, 1) == 1) ? LIP : $urandom;
        q = make_frame(ht, pt, hl, pl, op, 48'({$urandom, $urandom}), $urandom,
                       48'({$urandom, $urandom}), tpa, $urandom_range(0, 10));
        if (mode == 5) begin
            lim = $urandom_range(1, 27);
            while (q.size() > lim) void'(q.pop_back());
        end
        while (q.size() % bpb != 0) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_frame(i % 2, rand_frame((i % 2 == 0) ? 1 : 4), 1'($urandom_range(0, 1)), "random");
        end
`ifdef ARP_RX_STATS_EN
        checks++;
        if ({stat_ok_a, stat_err_a, stat_ok_b, stat_err_b} !==
            {16'(exp_ok[0]), 16'(exp_err[0]), 16'(exp_ok[1]), 16'(exp_err[1])}) begin
            errors++;
            $display("FAIL random_stats got %h want %h", {stat_ok_a, stat_err_a, stat_ok_b, stat_err_b},
                     {16'(exp_ok[0]), 16'(exp_err[0]), 16'(exp_ok[1]), 16'(exp_err[1])});
        end
`endif
    endtask

    task automatic test_back_to_back();
        bq_t fa, fb;
        int tb_done;
        ev_t e;
        do_reset();
        m_ready[0] = 1'b0;
        fa = good_frame(48'h0200000000AA, LIP, 16'd1, 0);
        fb = good_frame(48'h0200000000BB, 32'hC0A80105, 16'd2, 0);
        send(0, fa, 1'b0);
        send(0, fb, 1'b0);
        tb_done = beat_cyc[27] + 1;
        idle(0, 4);
        $display("frame back_to_back dut0 events=%0d m_valid=%0b", evq0.size(), m_valid_a);
        checks++;
        if (m_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending m_valid got %0b want 1", m_valid_a);
        end
        checks++;
        if ({m_op_a, m_sha_a, m_spa_a, m_tha_a, m_tpa_a, m_for_us_a} !== exp_fields(fa)) begin
            errors++;
            $display("FAIL b2b_hold fields got %h want %h",
                     {m_op_a, m_sha_a, m_spa_a, m_tha_a, m_tpa_a, m_for_us_a}, exp_fields(fa));
        end
        checks++;
        if (evq0.size() !== 1) begin
            errors++;
            $display("FAIL b2b_overflow event_count got %0d want 1", evq0.size());
        end else begin
            e = evq0.pop_front();
            checks++;
            if ({e.is_err, e.code, e.cyc} !== {1'b1, 3'd6, tb_done}) begin
                errors++;
                $display("FAIL b2b_overflow got err=%0b code=%0d cycle=%0d want err=1 code=6 cycle=%0d",
                         e.is_err, e.code, e.cyc, tb_done);
            end
        end
        evq0.delete();
        @(posedge clk); #1;
        m_ready[0] = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (evq0.size() !== 1) begin
            errors++;
            $display("FAIL b2b_consume event_count got %0d want 1", evq0.size());
        end else begin
            e = evq0.pop_front();
            checks++;
            if (e.fields !== exp_fields(fa)) begin
                errors++;
                $display("FAIL b2b_consume fields got %h want %h", e.fields, exp_fields(fa));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (m_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop m_valid got %0b want 0", m_valid_a);
        end
`ifdef ARP_RX_STATS_EN
        checks++;
        if ({stat_ok_a, stat_err_a} !== {16'd1, 16'd1}) begin
            errors++;
            $display("FAIL b2b_stats got ok=%0d err=%0d want ok=1 err=1", stat_ok_a, stat_err_a);
        end
`endif
        evq0.delete();
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 2'b00;
        s_last = 2'b00;
        m_ready = 2'b11;
        s_data_a = '0;
        s_data_b = '0;
        test_reset();
        test_basic();
        test_htype();
        test_oper();
        test_trunc();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout reached");
        $fatal(1);
    end

endmodule
